// File: rtl/eth_frame_fcs_update.sv
// rtl/eth_frame_fcs_update.sv - Ethernet FCS recompute/overwrite stage after frame edit
//
// Recomputes the reflected CRC-32 over the payload of each edited frame and overwrites the
// four trailing FCS bytes. When the frame is flagged corrupt, it can force a guaranteed-bad FCS.
// The stage forwards DROP_FRAME and reports whether any non-FCS byte differs from its original.
// Fixed latency: a beat driven in cycle n appears on m_axis in cycle n+6. There is no backpressure.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   s_axis_tdata    edited frame byte (frame includes its 4 FCS bytes)
//   s_axis_tuser    {ORIG_BYTE[7:0], DROP_FRAME, FCS_INVALID}; flags are final on the tlast beat
//   s_axis_tlast    last byte of frame
//   s_axis_tvalid   beat valid
//   m_axis_tdata    output byte
//   m_axis_tuser    {MODIFIED, DROP_FRAME, FCS_INVALID}; only on the tlast beat, otherwise 0
//   m_axis_tlast    last byte of frame
//   m_axis_tvalid   beat valid
module eth_frame_fcs_update #(
  parameter bit C_REWRITE_FCS       = 1'b1,
  parameter bit C_INVERT_ON_CORRUPT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic [9:0] s_axis_tuser,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic [2:0] m_axis_tuser,
  output logic       m_axis_tlast,
  output logic       m_axis_tvalid
);

  // One reflected CRC-32 byte step (poly 0x04C11DB7, LSB first).
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Input register
  logic        in_valid, in_last, in_diff, in_drop, in_inv;
  logic [7:0]  in_data;
  logic [10:0] cnt_q, cnt_n, cnt_base;

  // Delay line d0..d3 (index 3 is the slot feeding the output register)
  logic [3:0][7:0] d_data;
  logic [3:0]      d_valid, d_last, d_diff, d_drop, d_inv, d_fcs;
  logic [3:0][1:0] d_tag;

  logic [31:0] crc_q, crc_n;
  logic        mod_q, mod_n, mod_now;
  logic        do_tag;
  logic [7:0]  fcs_raw, fcs_sel, out_data_n;
  logic [2:0]  out_user_n;

  // Beat count of the frame whose beat sits in the input register. It restarts at 1
  // when a new frame's first beat follows a tlast directly, so no idle gap is needed.
  always_comb begin
    cnt_base = (in_valid && in_last) ? 11'd0 : cnt_q;
    cnt_n    = cnt_base;
    if (s_axis_tvalid && (cnt_base != 11'h7FF)) cnt_n = cnt_base + 11'd1;
  end

  // The last four beats are only treated as an FCS if the frame is long enough and they
  // are all still in the line. Otherwise the frame passes untouched and is flagged invalid.
  assign do_tag = in_valid && in_last && (cnt_q >= 11'd5) &&
                  d_valid[0] && d_valid[1] && d_valid[2];

  // Output stage: emit data or FCS byte, fold payload bytes into CRC, build flags on tlast.
  always_comb begin
    fcs_raw    = crc_q[{d_tag[3], 3'b000} +: 8];
    fcs_sel    = (d_inv[3] && C_INVERT_ON_CORRUPT) ? fcs_raw : ~fcs_raw;
    out_data_n = 8'h00;
    out_user_n = 3'b000;
    crc_n      = crc_q;
    mod_n      = mod_q;
    mod_now    = mod_q | (~d_fcs[3] & d_diff[3]);
    if (d_valid[3]) begin
      out_data_n = (C_REWRITE_FCS && d_fcs[3]) ? fcs_sel : d_data[3];
      if (d_last[3]) begin
        // An untagged tlast means a runt or a frame without a replaceable FCS.
        out_user_n = {mod_now, d_drop[3], d_fcs[3] ? d_inv[3] : 1'b1};
        mod_n      = 1'b0;
      end else begin
        mod_n      = mod_now;
      end
      if (C_REWRITE_FCS) begin
        // Restarting on every tlast, not only tag 3, keeps runts from corrupting the next frame.
        if (d_last[3])     crc_n = 32'hFFFFFFFF;
        else if (!d_fcs[3]) crc_n = crc32_byte(crc_q, d_data[3]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid      <= 1'b0;
      in_last       <= 1'b0;
      in_data       <= 8'h00;
      in_diff       <= 1'b0;
      in_drop       <= 1'b0;
      in_inv        <= 1'b0;
      cnt_q         <= 11'd0;
      d_data        <= '0;
      d_valid       <= '0;
      d_last        <= '0;
      d_diff        <= '0;
      d_drop        <= '0;
      d_inv         <= '0;
      d_fcs         <= '0;
      d_tag         <= '0;
      crc_q         <= 32'hFFFFFFFF;
      mod_q         <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tuser  <= 3'b000;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      in_valid <= s_axis_tvalid;
      in_last  <= s_axis_tvalid & s_axis_tlast;
      in_data  <= s_axis_tvalid ? s_axis_tdata : 8'h00;
      in_diff  <= s_axis_tvalid & (s_axis_tdata != s_axis_tuser[9:2]);
      in_drop  <= s_axis_tvalid & s_axis_tuser[1];
      in_inv   <= s_axis_tvalid & s_axis_tuser[0];
      cnt_q    <= cnt_n;

      d_data  <= {d_data[2:0], in_data};
      d_valid <= {d_valid[2:0], in_valid};
      d_last  <= {d_last[2:0], in_last};
      d_diff  <= {d_diff[2:0], in_diff};
      d_drop  <= {d_drop[2:0], in_drop};
      if (do_tag) begin
        // FCS bytes 0..3 leave d2, d1, d0 and in-reg in that order. They all carry the
        // tlast beat's final FCS_INVALID, so the corrupt choice is fixed per frame.
        d_fcs <= 4'b1111;
        d_tag <= {2'd0, 2'd1, 2'd2, 2'd3};
        d_inv <= {4{in_inv}};
      end else begin
        d_fcs <= {d_fcs[2:0], 1'b0};
        d_tag <= {d_tag[2:0], 2'd0};
        d_inv <= {d_inv[2:0], in_inv};
      end

      crc_q         <= crc_n;
      mod_q         <= mod_n;
      m_axis_tvalid <= d_valid[3];
      m_axis_tlast  <= d_last[3];
      m_axis_tdata  <= out_data_n;
      m_axis_tuser  <= out_user_n;
    end
  end

endmodule

// File: tb/tb_eth_frame_fcs_update.sv
// tb/tb_eth_frame_fcs_update.sv - self-checking bench for eth_frame_fcs_update
module tb_eth_frame_fcs_update;

  localparam int LAT = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic [9:0] s_axis_tuser;
  logic       s_axis_tlast;
  logic       s_axis_tvalid;
  logic [7:0] m_axis_tdata;
  logic [2:0] m_axis_tuser;
  logic       m_axis_tlast;
  logic       m_axis_tvalid;

  always #5 clk = ~clk;

  eth_frame_fcs_update dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [7:0] orig;
    logic       drop;
    logic       inv;
    logic       last;
  } beat_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [2:0] user;
  } exp_t;

  typedef struct {
    int           len;
    logic [127:0] data;    // byte i at [127-8i -: 8]
    int           mod_idx; // byte whose ORIG_BYTE is 0x00, -1 for none
    logic         drop;
    logic         inv;
    logic [31:0]  fcs;     // expected FCS bytes 0..3 at [31-8j -: 8]
    logic [2:0]   user;
  } vec_t;

  beat_t      in_q[$];
  exp_t       exp_q[$];
  logic [7:0] fd[$];
  logic [7:0] fo[$];
  vec_t       tbl[5];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input beat_t b);
    s_axis_tvalid = b.valid;
    s_axis_tdata  = b.data;
    s_axis_tuser  = {b.orig, b.drop, b.inv};
    s_axis_tlast  = b.last;
  endtask

  function automatic beat_t idle_beat();
    beat_t b;
    b = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    return b;
  endfunction

  function automatic logic [31:0] out_word();
    return {19'd0, m_axis_tvalid, m_axis_tvalid ? m_axis_tdata : 8'h00,
            m_axis_tvalid & m_axis_tlast, m_axis_tuser};
  endfunction

  function automatic logic [31:0] exp_word(input exp_t e);
    return {19'd0, e.valid, e.valid ? e.data : 8'h00, e.valid & e.last, e.user};
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_q.push_back(idle_beat());
      exp_q.push_back('{1'b0, 8'h00, 1'b0, 3'b000});
    end
  endtask

  // Ethernet FCS: CRC-32 over the payload, init all-ones, reflected, final complement.
  function automatic logic [31:0] fcs_ref(input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++)
      for (int b = 0; b < 8; b++)
        r = (r[0] ^ fd[k][b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return ~r;
  endfunction

  // Reference model over the frame held in fd/fo. Earlier beats carry a flag only from
  // beat sw onward, which keeps the flags cumulative and final on tlast.
  task automatic add_frame_model(input logic drop, input logic inv, input int sw);
    int          len, pay;
    logic [31:0] fcs;
    logic        mod;
    len = fd.size();
    pay = (len >= 5) ? len - 4 : len;
    fcs = fcs_ref(pay);
    if (inv) fcs = ~fcs;
    mod = 1'b0;
    for (int i = 0; i < pay; i++) if (fd[i] != fo[i]) mod = 1'b1;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      exp_t  e;
      b = '{1'b1, fd[i], fo[i], drop & (i >= sw), inv & (i >= sw), i == len - 1};
      e.valid = 1'b1;
      e.last  = (i == len - 1);
      e.data  = (i < pay) ? fd[i] : fcs[8*(i-pay) +: 8];
      e.user  = e.last ? {mod, drop, (len >= 5) ? inv : 1'b1} : 3'b000;
      in_q.push_back(b);
      exp_q.push_back(e);
    end
  endtask

  // Drive the queued timeline and compare each cycle's output against the entry LAT cycles earlier.
  task automatic run_timeline(input string tag);
    int n;
    n = in_q.size();
    for (int i = 0; i < n + LAT; i++) begin
      @(negedge clk);
      if (i >= LAT) check($sformatf("%s_cyc%0d", tag, i - LAT), out_word(), exp_word(exp_q[i-LAT]));
      drive((i < n) ? in_q[i] : idle_beat());
    end
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic load_t1();
    fd.delete();
    fo.delete();
    for (int i = 0; i < 9; i++) fd.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 4; i++) fd.push_back(8'h00);
    foreach (fd[i]) fo.push_back(fd[i]);
  endtask

  initial begin
    drive(idle_beat());
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors, applied back-to-back
    tbl[0] = '{13, {72'h313233343536373839, 56'h0}, -1, 1'b0, 1'b0, 32'h2639F4CB, 3'b000};
    tbl[1] = '{13, {72'h313233343536373839, 56'h0}, -1, 1'b0, 1'b1, 32'hD9C60B34, 3'b001};
    tbl[2] = '{13, {72'h313233343536373839, 56'h0},  2, 1'b1, 1'b0, 32'h2639F4CB, 3'b110};
    tbl[3] = '{ 3, {24'hAABBCC, 104'h0},            -1, 1'b0, 1'b0, 32'h0,        3'b001};
    tbl[4] = '{13, {72'h313233343536373839, 56'h0}, -1, 1'b0, 1'b0, 32'h2639F4CB, 3'b000};
    add_idle(2);
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < tbl[v].len; i++) begin
        beat_t       b;
        exp_t        e;
        logic [7:0]  byt;
        logic        is_last, is_fcs;
        byt     = tbl[v].data[127-8*i -: 8];
        is_last = (i == tbl[v].len - 1);
        is_fcs  = (tbl[v].len >= 5) && (i >= tbl[v].len - 4);
        b = '{1'b1, byt, (i == tbl[v].mod_idx) ? 8'h00 : byt,
              tbl[v].drop & is_last, tbl[v].inv & is_last, is_last};
        e.valid = 1'b1;
        e.last  = is_last;
        e.data  = is_fcs ? tbl[v].fcs[31-8*(i-(tbl[v].len-4)) -: 8] : byt;
        e.user  = is_last ? tbl[v].user : 3'b000;
        in_q.push_back(b);
        exp_q.push_back(e);
      end
    end
    add_idle(2);
    run_timeline("vec");

    // Random frames against the reference model; gaps of 0 give back-to-back frames
    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 24);
      fd.delete();
      fo.delete();
      for (int i = 0; i < len; i++) begin
        logic [7:0] d;
        d = 8'($urandom);
        fd.push_back(d);
        fo.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : d);
      end
      add_frame_model(1'($urandom), 1'($urandom), $urandom_range(0, len - 1));
      add_idle($urandom_range(0, 2));
    end
    run_timeline("rnd");

    // Reset in the middle of a frame, once output is already active
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive('{1'b1, 8'h31 + 8'(i), 8'h31 + 8'(i), 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk);
    check("pre_reset_active", {31'd0, m_axis_tvalid}, 32'd1);
    rst_n = 1'b0;
    drive(idle_beat());
    @(negedge clk);
    check("reset_mid_out", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check($sformatf("flush%0d", i), {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'd0);
    end
    // The residual tail becomes a 2-byte runt, followed by a clean frame
    fd.delete();
    fo.delete();
    fd.push_back(8'h38);
    fd.push_back(8'h39);
    fo.push_back(8'h38);
    fo.push_back(8'h39);
    add_frame_model(1'b0, 1'b0, 0);
    load_t1();
    add_frame_model(1'b0, 1'b0, 0);
    add_idle(1);
    run_timeline("rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
